// File: rtl/rv_trace_pkg.sv
// Shared types for the commit-trace buffer: record kind/size encodings, store funct3
// codes and the record layout at the default 32-bit XLEN / timestamp widths.
package rv_trace_pkg;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    REG  = 2'b01,
    MEM  = 2'b10
  } trace_kind_e;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } trace_size_e;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam int TRACE_XLEN    = 32;
  localparam int TRACE_CYCLE_W = 32;

  typedef struct packed {
    trace_kind_e              kind;
    trace_size_e              size;
    logic [TRACE_CYCLE_W-1:0] cycle;
    logic [TRACE_XLEN-1:0]    addr;
    logic [TRACE_XLEN-1:0]    data;
  } trace_rec_t;

  // Packed record width for an arbitrary XLEN / timestamp width.
  function automatic int rec_width(input int xlen, input int cycle_w);
    return 4 + cycle_w + 2 * xlen;
  endfunction

endpackage

// File: rtl/rv_trace_fifo2.sv
// Dual-push, single-pop show-ahead FIFO: a write is visible at the head one cycle later.
// The caller must never push more entries than 'free' reports; a same-cycle pop counts as free.
module rv_trace_fifo2 #(
  parameter  int W     = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    push_cnt,
  input  logic [W-1:0]  push0_dat,
  input  logic [W-1:0]  push1_dat,
  input  logic          pop_rdy,
  output logic          head_vld,
  output logic [W-1:0]  head_dat,
  output logic [LW-1:0] level,
  output logic [LW-1:0] free
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          pop;

  always_comb begin
    pop     = (level_q != '0) && pop_rdy;
    mem_d   = mem_q;
    if (push_cnt != 2'd0) mem_d[wptr_q] = push0_dat;
    if (push_cnt == 2'd2) mem_d[wptr_q + AW'(1)] = push1_dat;
    wptr_d  = wptr_q + AW'(push_cnt);
    rptr_d  = rptr_q + AW'(pop);
    level_d = level_q + LW'(push_cnt) - LW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_vld = (level_q != '0);
  assign head_dat = head_vld ? mem_q[rptr_q] : '0;
  assign level    = level_q;
  assign free     = LW'(DEPTH) - level_q + LW'(pop);

endmodule

// File: rtl/rv_trace_buffer.sv
// Commit-trace buffer: timestamps WB register writes and MEM stores into a dual-push FIFO, one cycle to head;
// a stalled consumer fills it and excess events are dropped and counted. Option: TRACE_ADDR_FILTER_EN.
module rv_trace_buffer
  import rv_trace_pkg::*;
#(
  parameter  int XLEN    = 32,
  parameter  int DEPTH   = 16,
  parameter  int CYCLE_W = 32,
  parameter  int DROP_W  = 16,
  localparam int LW      = $clog2(DEPTH) + 1,
  localparam int REC_W   = rec_width(XLEN, CYCLE_W)
) (
  input  logic              clk_c,
  input  logic              rst_c,
  input  logic              trace_en,
  input  logic              reg_write_w,
  input  logic [4:0]        rd_w,
  input  logic [XLEN-1:0]   result_w,
  input  logic              mem_write_m,
  input  logic [2:0]        funct3_m,
  input  logic [XLEN-1:0]   addr_m,
  input  logic [XLEN-1:0]   wdata_m,
  input  logic              clr_ovf,
`ifdef TRACE_ADDR_FILTER_EN
  input  logic [XLEN-1:0]   filt_lo,
  input  logic [XLEN-1:0]   filt_hi,
`endif
  output logic              trace_valid,
  input  logic              trace_ready,
  output logic [REC_W-1:0]  trace_rec,
  output logic [LW-1:0]     level,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              overflow
);

  typedef struct packed {
    trace_kind_e        kind;
    trace_size_e        size;
    logic [CYCLE_W-1:0] cycle;
    logic [XLEN-1:0]    addr;
    logic [XLEN-1:0]    data;
  } rec_t;

  logic [CYCLE_W-1:0] cycle_q, cycle_d;
  logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic               overflow_q, overflow_d;
  logic               reg_ev, mem_ev, mem_in_range;
  rec_t               reg_rec, mem_rec, push0_rec;
  logic [1:0]         n_ev, n_push, n_drop;
  logic [LW-1:0]      free;
  logic [DROP_W-1:0]  drop_base;
  logic [DROP_W:0]    drop_sum;

`ifdef TRACE_ADDR_FILTER_EN
  assign mem_in_range = (addr_m >= filt_lo) && (addr_m <= filt_hi);
`else
  assign mem_in_range = 1'b1;
`endif

  always_comb begin
    reg_ev        = trace_en && reg_write_w && (rd_w != 5'd0);
    mem_ev        = trace_en && mem_write_m && mem_in_range;

    reg_rec.kind  = REG;
    reg_rec.size  = WORD;
    reg_rec.cycle = cycle_q;
    reg_rec.addr  = XLEN'(rd_w);
    reg_rec.data  = result_w;

    mem_rec.kind  = MEM;
    mem_rec.size  = WORD;
    mem_rec.cycle = cycle_q;
    mem_rec.addr  = addr_m;
    mem_rec.data  = wdata_m;
    case (funct3_m)
      F3_SB: begin
        mem_rec.size = BYTE;
        mem_rec.data = XLEN'(wdata_m[7:0]);
      end
      F3_SH: begin
        mem_rec.size = HALF;
        mem_rec.data = XLEN'(wdata_m[15:0]);
      end
      F3_SW: begin
        mem_rec.size = WORD;
        mem_rec.data = wdata_m;
      end
      default: begin
        mem_rec.size = WORD;
        mem_rec.data = wdata_m;
      end
    endcase

    // REG always takes the lower slot, so with one free slot MEM is the one dropped.
    push0_rec = reg_ev ? reg_rec : mem_rec;
    n_ev      = {1'b0, reg_ev} + {1'b0, mem_ev};
    if (free == '0)            n_push = 2'd0;
    else if (free == LW'(1))   n_push = (n_ev != 2'd0) ? 2'd1 : 2'd0;
    else                       n_push = n_ev;
    n_drop    = n_ev - n_push;
  end

  always_comb begin
    cycle_d    = cycle_q + CYCLE_W'(1);
    drop_base  = clr_ovf ? '0 : drop_cnt_q;
    drop_sum   = {1'b0, drop_base} + (DROP_W + 1)'(n_drop);
    drop_cnt_d = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    overflow_d = (overflow_q && !clr_ovf) || (n_drop != 2'd0);
  end

  always_ff @(posedge clk_c or posedge rst_c) begin
    if (rst_c) begin
      cycle_q    <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      cycle_q    <= cycle_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  rv_trace_fifo2 #(
    .W     (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk_c),
    .rst       (rst_c),
    .push_cnt  (n_push),
    .push0_dat (push0_rec),
    .push1_dat (mem_rec),
    .pop_rdy   (trace_ready),
    .head_vld  (trace_valid),
    .head_dat  (trace_rec),
    .level     (level),
    .free      (free)
  );

  assign drop_cnt = drop_cnt_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_rv_trace_buffer.sv
// Bench for rv_trace_buffer: directed scenarios plus a randomized run against a queue-based model.
module tb_rv_trace_buffer;
  import rv_trace_pkg::*;

  localparam int XLEN    = 32;
  localparam int DEPTH   = 16;
  localparam int CYCLE_W = 32;
  localparam int DROP_W  = 16;
  localparam int LW      = $clog2(DEPTH) + 1;
  localparam int REC_W   = rec_width(XLEN, CYCLE_W);

  logic              clk_c = 1'b0;
  logic              rst_c = 1'b1;
  logic              trace_en = 1'b1;
  logic              reg_write_w = 1'b0;
  logic [4:0]        rd_w = '0;
  logic [XLEN-1:0]   result_w = '0;
  logic              mem_write_m = 1'b0;
  logic [2:0]        funct3_m = '0;
  logic [XLEN-1:0]   addr_m = '0;
  logic [XLEN-1:0]   wdata_m = '0;
  logic              clr_ovf = 1'b0;
`ifdef TRACE_ADDR_FILTER_EN
  logic [XLEN-1:0]   filt_lo = '0;
  logic [XLEN-1:0]   filt_hi = '1;
`endif
  logic              trace_valid;
  logic              trace_ready = 1'b0;
  logic [REC_W-1:0]  trace_rec;
  logic [LW-1:0]     level;
  logic [DROP_W-1:0] drop_cnt;
  logic              overflow;
  trace_rec_t        dut_rec;

  assign dut_rec = trace_rec;

  always #5 clk_c = ~clk_c;

  rv_trace_buffer #(
    .XLEN(XLEN), .DEPTH(DEPTH), .CYCLE_W(CYCLE_W), .DROP_W(DROP_W)
  ) dut (
    .clk_c(clk_c), .rst_c(rst_c), .trace_en(trace_en),
    .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w),
    .mem_write_m(mem_write_m), .funct3_m(funct3_m), .addr_m(addr_m), .wdata_m(wdata_m),
    .clr_ovf(clr_ovf),
`ifdef TRACE_ADDR_FILTER_EN
    .filt_lo(filt_lo), .filt_hi(filt_hi),
`endif
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_rec(trace_rec),
    .level(level), .drop_cnt(drop_cnt), .overflow(overflow)
  );

  // Reference model: FIFO contents as a queue, plus timestamp and drop bookkeeping.
  trace_rec_t  mq[$];
  int unsigned m_cyc;
  int unsigned m_drop;
  bit          m_ovf;
  int          checks = 0;
  int          errors = 0;

  function automatic trace_rec_t make_reg(input logic [4:0] rd, input logic [31:0] res, input int unsigned cyc);
    trace_rec_t r;
    r.kind = REG; r.size = WORD; r.cycle = cyc; r.addr = {27'd0, rd}; r.data = res;
    return r;
  endfunction

  function automatic trace_rec_t make_mem(input logic [31:0] a, input logic [31:0] wd,
                                          input logic [2:0] f3, input int unsigned cyc);
    trace_rec_t r;
    r.kind = MEM; r.cycle = cyc; r.addr = a;
    if (f3 == 3'b000)      begin r.size = BYTE; r.data = wd & 32'h0000_00FF; end
    else if (f3 == 3'b001) begin r.size = HALF; r.data = wd & 32'h0000_FFFF; end
    else                   begin r.size = WORD; r.data = wd; end
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_cyc  = 0;
    m_drop = 0;
    m_ovf  = 0;
  endtask

  task automatic idle_inputs();
    reg_write_w = 1'b0; rd_w = '0; result_w = '0;
    mem_write_m = 1'b0; funct3_m = '0; addr_m = '0; wdata_m = '0;
    clr_ovf = 1'b0;
  endtask

  // Advances the model by one clock using the pins as currently driven, then clocks the DUT.
  task automatic tick();
    trace_rec_t ev[$];
    bit  pop;
    int  fr;
    int  ndrop;
    bit  mem_ok;
    pop = (mq.size() != 0) && trace_ready;
    fr  = DEPTH - mq.size() + (pop ? 1 : 0);
    if (pop) void'(mq.pop_front());
    mem_ok = 1'b1;
`ifdef TRACE_ADDR_FILTER_EN
    mem_ok = (addr_m >= filt_lo) && (addr_m <= filt_hi);
`endif
    if (trace_en && reg_write_w && rd_w != 0) ev.push_back(make_reg(rd_w, result_w, m_cyc));
    if (trace_en && mem_write_m && mem_ok)    ev.push_back(make_mem(addr_m, wdata_m, funct3_m, m_cyc));
    ndrop = 0;
    for (int i = 0; i < ev.size(); i++) begin
      if (i < fr) mq.push_back(ev[i]);
      else        ndrop++;
    end
    if (clr_ovf) begin m_drop = 0; m_ovf = 0; end
    m_drop = m_drop + ndrop;
    if (m_drop > (2**DROP_W) - 1) m_drop = (2**DROP_W) - 1;
    if (ndrop != 0) m_ovf = 1;
    m_cyc = m_cyc + 1;
    @(posedge clk_c);
    @(negedge clk_c);
  endtask

  task automatic test_reset();
    rst_c = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk_c);
    checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", trace_valid); end
    checks++; if (trace_rec !== '0) begin errors++; $display("FAIL reset_rec: got %0h expected 0", trace_rec); end
    checks++; if (level !== '0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++; if (drop_cnt !== '0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b expected 0", overflow); end
    rst_c = 1'b0;
    model_reset();
  endtask

  task automatic test_reg_event();
    trace_ready = 1'b0;
    repeat (3) tick();
    reg_write_w = 1'b1; rd_w = 5'd5; result_w = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    checks++; if (trace_valid !== 1'b1) begin errors++; $display("FAIL reg_valid: got %0b expected 1", trace_valid); end
    checks++; if (dut_rec.kind !== REG) begin errors++; $display("FAIL reg_kind: got %0d expected %0d", dut_rec.kind, REG); end
    checks++; if (dut_rec.addr !== 32'd5) begin errors++; $display("FAIL reg_addr: got %0h expected 5", dut_rec.addr); end
    checks++; if (dut_rec.data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL reg_data: got %0h expected deadbeef", dut_rec.data); end
    checks++; if (dut_rec.cycle !== 32'd3) begin errors++; $display("FAIL reg_cycle: got %0d expected 3", dut_rec.cycle); end
    checks++; if (dut_rec.size !== WORD) begin errors++; $display("FAIL reg_size: got %0d expected %0d", dut_rec.size, WORD); end
    trace_ready = 1'b1;
    tick();
    checks++; if (level !== '0) begin errors++; $display("FAIL reg_drain: got %0d expected 0", level); end
  endtask

  task automatic test_mem_sizes();
    logic [2:0]  f3s  [3] = '{3'b000, 3'b001, 3'b011};
    logic [31:0] exps [3] = '{32'h0000_0078, 32'h0000_5678, 32'h1234_5678};
    trace_size_e szs  [3] = '{BYTE, HALF, WORD};
    for (int k = 0; k < 3; k++) begin
      trace_ready = 1'b0;
      reg_write_w = 1'b1; rd_w = 5'd0; result_w = 32'hFFFF_FFFF;
      mem_write_m = 1'b1; funct3_m = f3s[k]; addr_m = 32'h40; wdata_m = 32'h1234_5678;
      tick();
      idle_inputs();
      checks++; if (level !== LW'(1)) begin errors++; $display("FAIL mem%0d_level: got %0d expected 1", k, level); end
      checks++; if (dut_rec.kind !== MEM) begin errors++; $display("FAIL mem%0d_kind: got %0d expected %0d", k, dut_rec.kind, MEM); end
      checks++; if (dut_rec.data !== exps[k]) begin errors++; $display("FAIL mem%0d_data: got %0h expected %0h", k, dut_rec.data, exps[k]); end
      checks++; if (dut_rec.size !== szs[k]) begin errors++; $display("FAIL mem%0d_size: got %0d expected %0d", k, dut_rec.size, szs[k]); end
      checks++; if (dut_rec.addr !== 32'h40) begin errors++; $display("FAIL mem%0d_addr: got %0h expected 40", k, dut_rec.addr); end
      trace_ready = 1'b1;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int unsigned stamp;
    logic [31:0] wd;
    wd = $urandom;
    trace_ready = 1'b1;
    stamp = m_cyc;
    reg_write_w = 1'b1; rd_w = 5'd1; result_w = $urandom;
    mem_write_m = 1'b1; funct3_m = 3'b010; addr_m = $urandom; wdata_m = wd;
    tick();
    idle_inputs();
    checks++; if (level !== LW'(2)) begin errors++; $display("FAIL dual_level: got %0d expected 2", level); end
    checks++; if (dut_rec.kind !== REG || dut_rec.addr !== 32'd1) begin errors++; $display("FAIL dual_first: got kind %0d addr %0h expected REG addr 1", dut_rec.kind, dut_rec.addr); end
    checks++; if (dut_rec.cycle !== stamp) begin errors++; $display("FAIL dual_stamp0: got %0d expected %0d", dut_rec.cycle, stamp); end
    tick();
    checks++; if (dut_rec.kind !== MEM || dut_rec.data !== wd) begin errors++; $display("FAIL dual_second: got kind %0d data %0h expected MEM %0h", dut_rec.kind, dut_rec.data, wd); end
    checks++; if (dut_rec.cycle !== stamp) begin errors++; $display("FAIL dual_stamp1: got %0d expected %0d", dut_rec.cycle, stamp); end
    tick();
    checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL dual_empty: got %0b expected 0", trace_valid); end
  endtask

  task automatic test_overflow();
    trace_ready = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      reg_write_w = 1'b1; rd_w = 5'(i % 31 + 1); result_w = $urandom;
      tick();
    end
    idle_inputs();
    checks++; if (level !== LW'(DEPTH - 1)) begin errors++; $display("FAIL ovf_prefill: got %0d expected %0d", level, DEPTH - 1); end
    reg_write_w = 1'b1; rd_w = 5'd31; result_w = 32'hAAAA_0001;
    mem_write_m = 1'b1; funct3_m = 3'b010; addr_m = 32'h100; wdata_m = 32'hBBBB_0002;
    tick();
    idle_inputs();
    checks++; if (level !== LW'(DEPTH)) begin errors++; $display("FAIL ovf_level: got %0d expected %0d", level, DEPTH); end
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL ovf_drop1: got %0d expected 1", drop_cnt); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b expected 1", overflow); end
    mem_write_m = 1'b1; addr_m = 32'h104; wdata_m = 32'h1;
    tick();
    idle_inputs();
    checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL ovf_drop2: got %0d expected 2", drop_cnt); end
    clr_ovf = 1'b1;
    tick();
    idle_inputs();
    checks++; if (drop_cnt !== 16'd0 || overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %0d/%0b expected 0/0", drop_cnt, overflow); end
    clr_ovf = 1'b1; reg_write_w = 1'b1; rd_w = 5'd3; mem_write_m = 1'b1;
    tick();
    idle_inputs();
    checks++; if (drop_cnt !== 16'd2 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_clr_drop: got %0d/%0b expected 2/1", drop_cnt, overflow); end
    clr_ovf = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_full_pop_push();
    trace_ready = 1'b1;
    mem_write_m = 1'b1; funct3_m = 3'b000; addr_m = 32'h80; wdata_m = 32'h55AA;
    tick();
    idle_inputs();
    checks++; if (level !== LW'(DEPTH)) begin errors++; $display("FAIL fpp_level: got %0d expected %0d", level, DEPTH); end
    checks++; if (drop_cnt !== 16'd0 || overflow !== 1'b0) begin errors++; $display("FAIL fpp_nodrop: got %0d/%0b expected 0/0", drop_cnt, overflow); end
  endtask

  task automatic test_stall_stable();
    trace_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (dut_rec !== mq[0] || dut_rec.addr !== 32'd2) begin errors++; $display("FAIL stall_rec%0d: got %0h expected %0h", i, dut_rec, mq[0]); end
    end
    trace_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (dut_rec !== mq[0]) begin errors++; $display("FAIL drain%0d: got %0h expected %0h", i, dut_rec, mq[0]); end
      if (i == DEPTH - 2) begin
        checks++; if (dut_rec.kind !== REG || dut_rec.data !== 32'hAAAA_0001) begin errors++; $display("FAIL drain_dualreg: got kind %0d data %0h expected REG aaaa0001", dut_rec.kind, dut_rec.data); end
      end
      if (i == DEPTH - 1) begin
        checks++; if (dut_rec.kind !== MEM || dut_rec.data !== 32'h0000_00AA) begin errors++; $display("FAIL drain_last: got kind %0d data %0h expected MEM aa", dut_rec.kind, dut_rec.data); end
      end
      tick();
    end
    checks++; if (level !== '0) begin errors++; $display("FAIL drain_empty: got %0d expected 0", level); end
  endtask

  task automatic test_async_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      reg_write_w = 1'b1; rd_w = 5'(i + 1); result_w = $urandom;
      tick();
    end
    idle_inputs();
    trace_ready = 1'b1;
    repeat (2) tick();
    checks++; if (level !== LW'(7)) begin errors++; $display("FAIL arst_pre: got %0d expected 7", level); end
    #2 rst_c = 1'b1;
    #1;
    checks++; if (trace_valid !== 1'b0 || level !== '0) begin errors++; $display("FAIL arst_now: got valid %0b level %0d expected 0/0", trace_valid, level); end
    @(negedge clk_c);
    rst_c = 1'b0;
    model_reset();
    repeat (2) tick();
    reg_write_w = 1'b1; rd_w = 5'd9; result_w = 32'h9;
    tick();
    idle_inputs();
    checks++; if (dut_rec.cycle !== 32'd2 || trace_valid !== 1'b1) begin errors++; $display("FAIL arst_stamp: got cycle %0d valid %0b expected 2/1", dut_rec.cycle, trace_valid); end
    tick();
  endtask

  task automatic test_random();
    trace_rec_t exp_rec;
    for (int i = 0; i < 600; i++) begin
      trace_en    = ($urandom_range(0, 9) != 0);
      reg_write_w = $urandom_range(0, 1);
      rd_w        = 5'($urandom_range(0, 31));
      result_w    = $urandom;
      mem_write_m = $urandom_range(0, 1);
      funct3_m    = 3'($urandom_range(0, 7));
      addr_m      = $urandom;
      wdata_m     = $urandom;
      clr_ovf     = ($urandom_range(0, 19) == 0);
      trace_ready = ((i / 40) % 2 == 1) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2);
      tick();
      exp_rec = (mq.size() != 0) ? mq[0] : '0;
      checks++; if (trace_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rnd%0d_valid: got %0b expected %0b", i, trace_valid, mq.size() != 0); end
      checks++; if (level !== LW'(mq.size())) begin errors++; $display("FAIL rnd%0d_level: got %0d expected %0d", i, level, mq.size()); end
      checks++; if (dut_rec !== exp_rec) begin errors++; $display("FAIL rnd%0d_rec: got %0h expected %0h", i, dut_rec, exp_rec); end
      checks++; if (drop_cnt !== DROP_W'(m_drop)) begin errors++; $display("FAIL rnd%0d_drop: got %0d expected %0d", i, drop_cnt, m_drop); end
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd%0d_ovf: got %0b expected %0b", i, overflow, m_ovf); end
    end
    idle_inputs();
    trace_en = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    @(negedge clk_c);
    test_reset();
    test_reg_event();
    test_mem_sizes();
    test_back_to_back();
    test_overflow();
    test_full_pop_push();
    test_stall_stable();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_trace_buffer.md
Name: rv_trace_buffer

Overview:
- Synthesizable commit-trace buffer for the RV32I pipelined core; replaces simulation-only trace printing with a hardware record stream.
- Captures write-back register writes and MEM-stage stores, stamps each with a free-running cycle count, and queues the records in a dual-push FIFO.
- Records drain through a valid/ready port to a debug host or UART bridge.
- Generalises the single-width, print-only tracker: XLEN, FIFO depth and timestamp width are parameters, and it adds overflow accounting and backpressure.

Parameters:
- XLEN, 32, data/address width of traced values
- DEPTH, 16, FIFO entries; power of two, >= 4
- CYCLE_W, 32, timestamp width
- DROP_W, 16, drop-counter width

Ports:
- clk_c  in  1  clock
- rst_c  in  1  asynchronous reset, active-high
- trace_en  in  1  capture enable; draining continues when low
- reg_write_w  in  1  WB register-write strobe
- rd_w  in  5  WB destination register
- result_w  in  XLEN  WB write data
- mem_write_m  in  1  MEM store strobe
- funct3_m  in  3  store size (000 byte, 001 half, 010 word)
- addr_m  in  XLEN  store address (ALU result)
- wdata_m  in  XLEN  store data
- clr_ovf  in  1  synchronous clear of overflow and drop_cnt
- trace_valid  out  1  record available
- trace_ready  in  1  consumer accepts record
- trace_rec  out  trace_rec_t  head record
- level  out  $clog2(DEPTH)+1  occupied entries
- drop_cnt  out  DROP_W  dropped events, saturating
- overflow  out  1  sticky: at least one drop since clear

Behaviour:
- Reset values: trace_valid 0, trace_rec all-zero, level 0, drop_cnt 0, overflow 0. The cycle counter and FIFO pointers reset to 0.
- Cycle counter: increments every clock after reset, independent of trace_en, and wraps modulo 2^CYCLE_W. The first edge after reset release stamps 0.
- REG event:
  - Triggered by trace_en && reg_write_w && rd_w != 0; writes to x0 are never recorded.
  - Record: kind=REG, size=WORD, addr=rd_w zero-extended, data=result_w.
- MEM event:
  - Triggered by trace_en && mem_write_m.
  - Record: kind=MEM, addr=addr_m.
  - Data by funct3_m: 000 gives wdata_m[7:0] zero-extended, size=BYTE. 001 gives [15:0] zero-extended, size=HALF. 010 and any other value give the full word, size=WORD.
- Dual push: both events in one cycle give two pushes. REG occupies the lower slot and MEM the next, so REG precedes MEM in drain order. Both records carry the same stamp.
- Free space: free = DEPTH - level + (trace_valid && trace_ready). A pop frees a slot for a same-cycle push.
- Overflow cases:
  - Two events, one free slot: REG is pushed and MEM is dropped.
  - Zero free slots: all events that cycle are dropped.
- Drop accounting:
  - drop_cnt increases by the number dropped (0-2) and saturates at all-ones.
  - overflow sets on any drop.
  - clr_ovf zeroes both. If a drop occurs in the same cycle, clear wins, then the new drops are counted (drop_cnt = number dropped, overflow = 1).
- Latency: an event in cycle N is visible on trace_rec/trace_valid at N+1 if the FIFO was empty. The FIFO uses registered storage with a show-ahead head.
- Handshake:
  - Pop occurs on trace_valid && trace_ready.
  - trace_rec is stable while trace_valid && !trace_ready.
  - trace_valid = (level != 0).
- Pointers: wrap modulo DEPTH. level is updated as +pushes - pop, with a range of 0..DEPTH.
- Reset mid-stream: contents are discarded and the counter restarts at 0.

Optional Feature:
- Macro TRACE_ADDR_FILTER_EN adds input ports filt_lo and filt_hi (XLEN each).
- With the macro: a MEM event is recorded only if filt_lo <= addr_m <= filt_hi (unsigned). Filtered stores are not counted as drops.
- Without the macro: the ports are absent and all stores are recorded.

Decomposition:
- Package rv_trace_pkg holds:
  - trace_kind_e: NONE=2'b00, REG=2'b01, MEM=2'b10
  - trace_size_e: BYTE=2'b00, HALF=2'b01, WORD=2'b10
  - parameterised packed trace_rec_t: {kind, size, cycle, addr, data}
  - funct3 store encodings
- Sub-module rv_trace_fifo2: a dual-push, single-pop show-ahead FIFO with a free-space output. Event formatting and drop logic stay in the top.

Test Plan:
- Reset release, reg_write_w=1, rd_w=5, result_w=32'hDEADBEEF at cycle 3. Next cycle: trace_valid=1, kind=REG, addr=5, data=DEADBEEF, cycle=3.
- Same cycle: rd_w=0 write plus store funct3=000, addr_m=0x40, wdata_m=0x12345678. Exactly one record: MEM, size=BYTE, data=0x00000078. Then funct3=001 gives data=0x00005678, size=HALF.
- Simultaneous REG (rd=1) and MEM (word) with trace_ready=1. Drain order is REG then MEM, with identical cycle stamps.
- trace_ready=0; push DEPTH-1 records, then a dual event. level=DEPTH, drop_cnt=1, overflow=1, last record kind=REG. A further event gives drop_cnt=2. Then clr_ovf gives 0/0.
- Full FIFO with trace_ready=1 and a single event in the same cycle: no drop, level stays DEPTH. Hold trace_ready=0: trace_rec is stable across 5 cycles.
- Assert rst_c asynchronously mid-drain with level=7. trace_valid=0 and level=0 immediately, and the next event stamps the cycle relative to the new release.
